// File: rtl/ma_clks_group_ctrl.sv
// Clock-group reconfiguration sequencer: round-robin arbitration over per-domain
// requests, then gate -> wait -> load divider and toggle -> settle -> ungate.
module ma_clks_group_ctrl #(
    parameter int unsigned DIV_DW      = 4,
    parameter int unsigned N_DOM       = 5,
    parameter int unsigned GATE_WAIT   = 8,
    parameter int unsigned SETTLE_WAIT = 16,
    parameter int unsigned RST_DIV     = 1
) (
    input  logic                    src_clk,
    input  logic                    src_rst,
    input  logic [N_DOM-1:0]        req_vld,
    input  logic [N_DOM*DIV_DW-1:0] req_div,
    input  logic [N_DOM-1:0]        req_cken,
    output logic [N_DOM-1:0]        req_ack,
    output logic                    busy,
    output logic [N_DOM*DIV_DW-1:0] div_o,
    output logic [N_DOM-1:0]        tog_o,
    output logic [N_DOM-1:0]        cken_o,
    output logic [N_DOM-1:0]        icg_on_o
);

    localparam int unsigned MAX_WAIT = (GATE_WAIT > SETTLE_WAIT) ? GATE_WAIT : SETTLE_WAIT;
    localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);
    localparam int unsigned IDX_W    = (N_DOM > 1) ? $clog2(N_DOM) : 1;
    localparam int unsigned CW       = IDX_W + 1;

    localparam logic [CNT_W-1:0]  GATE_LOAD   = CNT_W'(GATE_WAIT - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_WAIT - 1);
    localparam logic [DIV_DW-1:0] RST_DIV_F   = DIV_DW'(RST_DIV);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(N_DOM - 1);

    typedef enum logic [1:0] {IDLE, WAIT_G, WAIT_S} state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   cur;
    logic [CNT_W-1:0]   counter;
    logic [DIV_DW-1:0]  cap_div;
    logic               cap_cken;

    logic [N_DOM-1:0]   eligible;
    logic               grant_vld;
    logic [IDX_W-1:0]   grant_idx;
    logic [CW-1:0]      cand;

    // The domain just acked is masked so its still-high req_vld is not re-granted.
    always_comb begin
        eligible  = req_vld & ~req_ack;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N_DOM; i++) begin
            cand = {1'b0, rr_ptr} + CW'(i);
            if (cand >= CW'(N_DOM)) begin
                cand = cand - CW'(N_DOM);
            end
            if (!grant_vld && eligible[cand[IDX_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge src_clk) begin
        if (src_rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            cur      <= '0;
            counter  <= '0;
            cap_div  <= '0;
            cap_cken <= 1'b0;
            for (int unsigned i = 0; i < N_DOM; i++) begin
                div_o[i*DIV_DW +: DIV_DW] <= RST_DIV_F;
            end
            tog_o    <= '0;
            cken_o   <= '1;
            icg_on_o <= '1;
            req_ack  <= '0;
        end else begin
            req_ack <= '0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        state               <= WAIT_G;
                        cur                 <= grant_idx;
                        cap_div             <= req_div[grant_idx*DIV_DW +: DIV_DW];
                        cap_cken            <= req_cken[grant_idx];
                        icg_on_o[grant_idx] <= 1'b0;
                        counter             <= GATE_LOAD;
                        rr_ptr              <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
                    end
                end
                WAIT_G: begin
                    if (counter == '0) begin
                        state                       <= WAIT_S;
                        div_o[cur*DIV_DW +: DIV_DW] <= cap_div;
                        cken_o[cur]                 <= cap_cken;
                        tog_o[cur]                  <= ~tog_o[cur];
                        counter                     <= SETTLE_LOAD;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                WAIT_S: begin
                    if (counter == '0) begin
                        state         <= IDLE;
                        icg_on_o[cur] <= cap_cken;
                        req_ack[cur]  <= 1'b1;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
